// File: rtl/acc_pkg.sv
// Shared definitions for the temporal-accumulation transmit path: lane geometry,
// FSM states and the default flush length that also feeds the acc_temporal latency budget.
package acc_pkg;

    localparam int LANES         = 16;
    localparam int LANE_W        = 16;
    localparam int DATA_W        = LANES * LANE_W;
    localparam int FLUSH_CYC_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/acc_vec_fifo.sv
// Synchronous vector FIFO with an extra pointer bit to tell full from empty.
// The head entry is presented combinationally so the caller can register it on pop.
module acc_vec_fifo
    import acc_pkg::*;
#(
    parameter int DATA_W     = acc_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       rd_ptr_q;
    logic              do_push;
    logic              do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset: resetting the pointers already discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/acc_stream_tx.sv
// Frames buffered partial-sum vectors into accumulation groups for acc_temporal,
// forcing a flush gap after every group-closing beat.
module acc_stream_tx
    import acc_pkg::*;
#(
    parameter int DATA_W     = acc_pkg::DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int FLUSH_CYC  = FLUSH_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [CNT_W-1:0]  cfg_group_len,
    input  logic [CNT_W-1:0]  cfg_num_groups,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_vector,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_vector,
    output logic              tx_accum_done,
    output logic              busy,
    output logic              done
);

    localparam int FC_W = $clog2(FLUSH_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FLUSH_CYC - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  len_q, len_d;
    logic [CNT_W-1:0]  ngrp_q, ngrp_d;
    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [CNT_W-1:0]  grp_q, grp_d;
    logic [FC_W-1:0]   fcnt_q, fcnt_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tx_valid_q, tx_valid_d;
    logic              tx_done_q, tx_done_d;
    logic [DATA_W-1:0] tx_vector_q, tx_vector_d;

    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;

    acc_vec_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (s_valid),
        .wdata_i (s_vector),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign s_ready       = !fifo_full;
    assign tx_valid      = tx_valid_q;
    assign tx_vector     = tx_vector_q;
    assign tx_accum_done = tx_done_q;
    assign busy          = busy_q;
    assign done          = done_q;

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        ngrp_d      = ngrp_q;
        beat_d      = beat_q;
        grp_d       = grp_q;
        fcnt_d      = fcnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tx_valid_d  = 1'b0;
        tx_done_d   = 1'b0;
        tx_vector_d = tx_vector_q;
        fifo_pop    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    if (cfg_group_len != '0 && cfg_num_groups != '0) begin
                        len_d   = cfg_group_len;
                        ngrp_d  = cfg_num_groups;
                        beat_d  = '0;
                        grp_d   = '0;
                        busy_d  = 1'b1;
                        state_d = STREAM;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (!fifo_empty) begin
                    fifo_pop    = 1'b1;
                    tx_valid_d  = 1'b1;
                    tx_vector_d = fifo_head;
                    if (beat_q == len_q - CNT_ONE) begin
                        tx_done_d = 1'b1;
                        beat_d    = '0;
                        grp_d     = grp_q + CNT_ONE;
                        fcnt_d    = '0;
                        state_d   = FLUSH;
                    end else begin
                        beat_d = beat_q + CNT_ONE;
                    end
                end
            end
            FLUSH: begin
                // The closing beat is already on tx_*; these cycles are the idle gap.
                if (fcnt_q == FC_LAST) begin
                    fcnt_d  = '0;
                    state_d = (grp_q == ngrp_q) ? DONE : STREAM;
                end else begin
                    fcnt_d = fcnt_q + FC_ONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            len_q       <= '0;
            ngrp_q      <= '0;
            beat_q      <= '0;
            grp_q       <= '0;
            fcnt_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_done_q   <= 1'b0;
            tx_vector_q <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            ngrp_q      <= ngrp_d;
            beat_q      <= beat_d;
            grp_q       <= grp_d;
            fcnt_q      <= fcnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            tx_valid_q  <= tx_valid_d;
            tx_done_q   <= tx_done_d;
            tx_vector_q <= tx_vector_d;
        end
    end

endmodule

// File: tb/tb_acc_stream_tx.sv
// Bench for acc_stream_tx: drives jobs and vector streams, captures the tx stream,
// and checks it against the expected grouping, ordering and timing rules.
module tb_acc_stream_tx;

    localparam int DW = 256;
    localparam int CW = 8;
    localparam int FC = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [CW-1:0] cfg_group_len;
    logic [CW-1:0] cfg_num_groups;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_vector;
    logic          tx_valid;
    logic [DW-1:0] tx_vector;
    logic          tx_accum_done;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // source stimulus: vectors and idle cycles before each one
    logic [DW-1:0] src_q[$];
    int            src_dly[$];
    // captured tx stream
    logic [DW-1:0] obs_vec[$];
    logic          obs_done[$];
    int            obs_cyc[$];
    int            done_cyc, done_cnt, orphan, hold_err, busy_hi;
    bit            timed_out;
    logic [DW-1:0] last_vec;

    acc_stream_tx dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_start      (cfg_start),
        .cfg_group_len  (cfg_group_len),
        .cfg_num_groups (cfg_num_groups),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .s_vector       (s_vector),
        .tx_valid       (tx_valid),
        .tx_vector      (tx_vector),
        .tx_accum_done  (tx_accum_done),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rvec();
        logic [DW-1:0] v;
        for (int w = 0; w < DW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    // Runs cycles, sampling at negedge and driving for the next posedge.
    task automatic collect(input int start_cyc, input int len, input int grp,
                           input int start2_cyc, input int len2, input int grp2,
                           input int stop_beats, input int budget);
        int cyc;
        bit fin;
        obs_vec.delete(); obs_done.delete(); obs_cyc.delete();
        done_cyc = -1; done_cnt = 0; orphan = 0; hold_err = 0; busy_hi = 0; timed_out = 0;
        cyc = 0; fin = 0;
        while (!fin) begin
            @(negedge clk);
            if (tx_valid) begin
                obs_vec.push_back(tx_vector);
                obs_done.push_back(tx_accum_done);
                obs_cyc.push_back(cyc);
                last_vec = tx_vector;
            end else if (tx_vector !== last_vec) begin
                hold_err++;
            end
            if (tx_accum_done && !tx_valid) orphan++;
            if (busy) busy_hi++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            cfg_start = 1'b0;
            if (cyc == start_cyc) begin
                cfg_start = 1'b1; cfg_group_len = CW'(len); cfg_num_groups = CW'(grp);
            end
            if (cyc == start2_cyc) begin
                cfg_start = 1'b1; cfg_group_len = CW'(len2); cfg_num_groups = CW'(grp2);
            end
            s_valid = 1'b0;
            if (src_q.size() > 0) begin
                if (src_dly[0] > 0) begin
                    src_dly[0] = src_dly[0] - 1;
                end else begin
                    s_valid  = 1'b1;
                    s_vector = src_q[0];
                    if (s_ready) begin
                        void'(src_q.pop_front());
                        void'(src_dly.pop_front());
                    end
                end
            end
            if (stop_beats > 0 && obs_vec.size() >= stop_beats) fin = 1;
            if (done_cyc >= 0 && cyc >= done_cyc + 2) fin = 1;
            cyc++;
            if (!fin && cyc >= budget) begin
                timed_out = 1;
                fin = 1;
            end
        end
    endtask

    task automatic test_reset();
        total++; if (tx_valid !== 1'b0) begin bad++; $display("FAIL rst_tx_valid got=%b want=0", tx_valid); end
        total++; if (tx_vector !== '0) begin bad++; $display("FAIL rst_tx_vector got=%h want=0", tx_vector); end
        total++; if (tx_accum_done !== 1'b0) begin bad++; $display("FAIL rst_accum_done got=%b want=0", tx_accum_done); end
        total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rst_busy_done got=%b%b want=00", busy, done); end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL rst_s_ready got=%b want=1", s_ready); end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vecs[$];
        logic [DW-1:0] v;
        for (int k = 1; k <= 4; k++) begin
            v = rvec(); v[15:0] = 16'(k);
            vecs.push_back(v); src_q.push_back(v); src_dly.push_back(0);
        end
        collect(0, 4, 1, -1, 0, 0, 0, 100);
        total++; if (timed_out || obs_vec.size() != 4) begin bad++; $display("FAIL b2b_count got=%0d want=4 timeout=%0d", obs_vec.size(), timed_out); end
        for (int i = 0; i < 4 && i < obs_vec.size(); i++) begin
            total++; if (obs_vec[i] !== vecs[i]) begin bad++; $display("FAIL b2b_data[%0d] got=%h want=%h", i, obs_vec[i], vecs[i]); end
            total++; if (obs_done[i] !== (i == 3)) begin bad++; $display("FAIL b2b_accum[%0d] got=%b want=%b", i, obs_done[i], i == 3); end
            if (i > 0) begin
                total++; if (obs_cyc[i] != obs_cyc[i-1] + 1) begin bad++; $display("FAIL b2b_consec[%0d] got=%0d want=%0d", i, obs_cyc[i], obs_cyc[i-1] + 1); end
            end
        end
        if (obs_vec.size() == 4) begin
            total++; if (done_cyc - obs_cyc[3] != FC + 1) begin bad++; $display("FAIL b2b_done_lat got=%0d want=%0d", done_cyc - obs_cyc[3], FC + 1); end
        end
        total++; if (done_cnt != 1 || busy !== 1'b0) begin bad++; $display("FAIL b2b_end done_cnt=%0d busy=%b want 1/0", done_cnt, busy); end
        total++; if (orphan != 0 || hold_err != 0) begin bad++; $display("FAIL b2b_hygiene orphan=%0d hold=%0d want 0/0", orphan, hold_err); end
    endtask

    task automatic test_multi_group();
        logic [DW-1:0] vecs[$];
        for (int k = 0; k < 6; k++) begin
            vecs.push_back(rvec()); src_q.push_back(vecs[k]); src_dly.push_back(0);
        end
        collect(5, 3, 2, -1, 0, 0, 0, 200);
        total++; if (timed_out || obs_vec.size() != 6) begin bad++; $display("FAIL mg_count got=%0d want=6 timeout=%0d", obs_vec.size(), timed_out); end
        for (int i = 0; i < 6 && i < obs_vec.size(); i++) begin
            total++; if (obs_vec[i] !== vecs[i]) begin bad++; $display("FAIL mg_data[%0d] got=%h want=%h", i, obs_vec[i], vecs[i]); end
            total++; if (obs_done[i] !== ((i % 3) == 2)) begin bad++; $display("FAIL mg_accum[%0d] got=%b want=%b", i, obs_done[i], (i % 3) == 2); end
        end
        if (obs_vec.size() == 6) begin
            total++; if (obs_cyc[3] - obs_cyc[2] - 1 != FC) begin bad++; $display("FAIL mg_flush_gap got=%0d want=%0d", obs_cyc[3] - obs_cyc[2] - 1, FC); end
        end
        total++; if (done_cnt != 1 || orphan != 0 || hold_err != 0) begin bad++; $display("FAIL mg_end done_cnt=%0d orphan=%0d hold=%0d want 1/0/0", done_cnt, orphan, hold_err); end
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] vecs[$];
        for (int k = 0; k < 5; k++) begin
            vecs.push_back(rvec()); src_q.push_back(vecs[k]); src_dly.push_back(0);
        end
        collect(-1, 0, 0, -1, 0, 0, 0, 8);
        total++; if (s_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%b want=0", s_ready); end
        total++; if (src_q.size() != 1) begin bad++; $display("FAIL bp_held got=%0d want=1", src_q.size()); end
        total++; if (obs_vec.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL bp_idle beats=%0d busy=%b want 0/0", obs_vec.size(), busy); end
        collect(0, 5, 1, -1, 0, 0, 0, 100);
        total++; if (timed_out || obs_vec.size() != 5) begin bad++; $display("FAIL bp_count got=%0d want=5 timeout=%0d", obs_vec.size(), timed_out); end
        for (int i = 0; i < 5 && i < obs_vec.size(); i++) begin
            total++; if (obs_vec[i] !== vecs[i]) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", i, obs_vec[i], vecs[i]); end
            total++; if (obs_done[i] !== (i == 4)) begin bad++; $display("FAIL bp_accum[%0d] got=%b want=%b", i, obs_done[i], i == 4); end
        end
        total++; if (s_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_back got=%b want=1", s_ready); end
    endtask

    task automatic test_starved();
        logic [DW-1:0] vecs[$];
        vecs.push_back(rvec()); vecs.push_back(rvec());
        src_q.push_back(vecs[0]); src_dly.push_back(2);
        src_q.push_back(vecs[1]); src_dly.push_back(3);
        collect(0, 2, 1, -1, 0, 0, 0, 100);
        total++; if (timed_out || obs_vec.size() != 2) begin bad++; $display("FAIL stv_count got=%0d want=2 timeout=%0d", obs_vec.size(), timed_out); end
        if (obs_vec.size() == 2) begin
            total++; if (obs_cyc[1] - obs_cyc[0] - 1 != 3) begin bad++; $display("FAIL stv_bubbles got=%0d want=3", obs_cyc[1] - obs_cyc[0] - 1); end
            total++; if (obs_done[0] !== 1'b0 || obs_done[1] !== 1'b1) begin bad++; $display("FAIL stv_accum got=%b%b want=01", obs_done[0], obs_done[1]); end
            total++; if (obs_vec[0] !== vecs[0] || obs_vec[1] !== vecs[1]) begin bad++; $display("FAIL stv_data got=%h want=%h", obs_vec[1], vecs[1]); end
        end
        total++; if (hold_err != 0 || orphan != 0) begin bad++; $display("FAIL stv_hygiene hold=%0d orphan=%0d want 0/0", hold_err, orphan); end
    endtask

    task automatic test_zero_cfg();
        collect(0, 0, 3, -1, 0, 0, 0, 20);
        total++; if (done_cyc != 1 || done_cnt != 1) begin bad++; $display("FAIL zlen_done got_cyc=%0d cnt=%0d want 1/1", done_cyc, done_cnt); end
        total++; if (obs_vec.size() != 0 || busy_hi != 0) begin bad++; $display("FAIL zlen_quiet beats=%0d busy_cycles=%0d want 0/0", obs_vec.size(), busy_hi); end
        collect(0, 5, 0, -1, 0, 0, 0, 20);
        total++; if (done_cyc != 1 || obs_vec.size() != 0 || busy_hi != 0) begin bad++; $display("FAIL zgrp got_cyc=%0d beats=%0d busy=%0d want 1/0/0", done_cyc, obs_vec.size(), busy_hi); end
    endtask

    task automatic test_busy_start();
        logic [DW-1:0] vecs[$];
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(rvec()); src_q.push_back(vecs[k]); src_dly.push_back(0);
        end
        collect(0, 2, 2, 3, 1, 1, 0, 100);
        total++; if (timed_out || obs_vec.size() != 4) begin bad++; $display("FAIL bsy_count got=%0d want=4 timeout=%0d", obs_vec.size(), timed_out); end
        for (int i = 0; i < 4 && i < obs_vec.size(); i++) begin
            total++; if (obs_done[i] !== ((i % 2) == 1) || obs_vec[i] !== vecs[i]) begin bad++; $display("FAIL bsy_beat[%0d] accum=%b want=%b data=%h want=%h", i, obs_done[i], (i % 2) == 1, obs_vec[i], vecs[i]); end
        end
        total++; if (done_cnt != 1) begin bad++; $display("FAIL bsy_done_cnt got=%0d want=1", done_cnt); end
    endtask

    task automatic test_max_len();
        logic [DW-1:0] vecs[$];
        int            nacc;
        for (int k = 0; k < 255; k++) begin
            vecs.push_back(rvec()); src_q.push_back(vecs[k]); src_dly.push_back(0);
        end
        collect(0, 255, 1, -1, 0, 0, 0, 2000);
        total++; if (timed_out || obs_vec.size() != 255) begin bad++; $display("FAIL max_count got=%0d want=255 timeout=%0d", obs_vec.size(), timed_out); end
        nacc = 0;
        for (int i = 0; i < obs_vec.size(); i++) if (obs_done[i]) nacc++;
        total++; if (nacc != 1 || (obs_vec.size() == 255 && obs_done[254] !== 1'b1)) begin bad++; $display("FAIL max_accum got=%0d want=1 on last", nacc); end
        for (int i = 0; i < 255 && i < obs_vec.size(); i++) begin
            total++; if (obs_vec[i] !== vecs[i]) begin bad++; $display("FAIL max_data[%0d] got=%h want=%h", i, obs_vec[i], vecs[i]); end
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] vecs[$];
        int len, grp, n;
        for (int it = 0; it < 6; it++) begin
            len = (it == 0) ? 1 : $urandom_range(1, 5);
            grp = (it == 0) ? 3 : $urandom_range(1, 3);
            n = len * grp;
            vecs.delete();
            for (int k = 0; k < n; k++) begin
                vecs.push_back(rvec()); src_q.push_back(vecs[k]); src_dly.push_back($urandom_range(0, 2));
            end
            collect(0, len, grp, -1, 0, 0, 0, 500);
            total++; if (timed_out || obs_vec.size() != n) begin bad++; $display("FAIL rnd%0d_count got=%0d want=%0d timeout=%0d", it, obs_vec.size(), n, timed_out); end
            for (int i = 0; i < n && i < obs_vec.size(); i++) begin
                total++; if (obs_vec[i] !== vecs[i]) begin bad++; $display("FAIL rnd%0d_data[%0d] got=%h want=%h", it, i, obs_vec[i], vecs[i]); end
                total++; if (obs_done[i] !== ((i % len) == len - 1)) begin bad++; $display("FAIL rnd%0d_accum[%0d] got=%b want=%b", it, i, obs_done[i], (i % len) == len - 1); end
                if (obs_done[i] && i + 1 < obs_vec.size()) begin
                    total++; if (obs_cyc[i+1] - obs_cyc[i] - 1 < FC) begin bad++; $display("FAIL rnd%0d_gap[%0d] got=%0d want>=%0d", it, i, obs_cyc[i+1] - obs_cyc[i] - 1, FC); end
                end
            end
            if (obs_vec.size() == n) begin
                total++; if (done_cyc - obs_cyc[n-1] != FC + 1) begin bad++; $display("FAIL rnd%0d_done_lat got=%0d want=%0d", it, done_cyc - obs_cyc[n-1], FC + 1); end
            end
            total++; if (done_cnt != 1 || busy !== 1'b0 || orphan != 0 || hold_err != 0) begin bad++; $display("FAIL rnd%0d_end done_cnt=%0d busy=%b orphan=%0d hold=%0d want 1/0/0/0", it, done_cnt, busy, orphan, hold_err); end
        end
    endtask

    task automatic test_reset_mid();
        logic [DW-1:0] vecs[$];
        for (int k = 0; k < 4; k++) begin
            vecs.push_back(rvec()); src_q.push_back(vecs[k]); src_dly.push_back(0);
        end
        collect(0, 4, 1, -1, 0, 0, 2, 100);
        cfg_start = 1'b0; s_valid = 1'b0;
        src_q.delete(); src_dly.delete();
        total++; if (obs_vec.size() != 2 || busy !== 1'b1) begin bad++; $display("FAIL rm_pre beats=%0d busy=%b want 2/1", obs_vec.size(), busy); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (tx_valid !== 1'b0 || tx_accum_done !== 1'b0 || tx_vector !== '0) begin bad++; $display("FAIL rm_tx got=%b%b vec=%h want 00/0", tx_valid, tx_accum_done, tx_vector); end
        total++; if (busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b1) begin bad++; $display("FAIL rm_ctrl busy=%b done=%b ready=%b want 0/0/1", busy, done, s_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        last_vec = '0;
        vecs.delete();
        for (int k = 0; k < 2; k++) begin
            vecs.push_back(rvec()); src_q.push_back(vecs[k]); src_dly.push_back(1);
        end
        collect(0, 2, 1, -1, 0, 0, 0, 100);
        total++; if (timed_out || obs_vec.size() != 2) begin bad++; $display("FAIL rm_new_count got=%0d want=2 timeout=%0d", obs_vec.size(), timed_out); end
        for (int i = 0; i < 2 && i < obs_vec.size(); i++) begin
            total++; if (obs_vec[i] !== vecs[i]) begin bad++; $display("FAIL rm_new_data[%0d] got=%h want=%h", i, obs_vec[i], vecs[i]); end
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_start = 1'b0; cfg_group_len = '0; cfg_num_groups = '0;
        s_valid = 1'b0; s_vector = '0; last_vec = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        test_reset();
        test_back_to_back();
        test_multi_group();
        test_backpressure();
        test_starved();
        test_zero_cfg();
        test_busy_start();
        test_max_len();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_stream_tx.md
Name: acc_stream_tx

Overview:
- Transmit side of the temporal-accumulation interface. Buffers 256-bit partial-sum vectors (16 fp16 lanes) arriving from the PE array.
- Streams them to the temporal accumulator as in_valid / in_vector / in_accum_done, framed into groups of a programmed length.
- Inserts flush gaps between groups so the accumulator pipeline can emit each result.
- Sits between the PE-array result path and acc_temporal.

Parameters:
- DATA_W, 256, vector width (16 lanes x 16-bit fp16).
- FIFO_DEPTH, 4, input buffer depth in vectors (power of 2, >=2).
- CNT_W, 8, width of the group-length and group-count counters.
- FLUSH_CYC, 2, idle cycles forced after each accum_done beat (>=1).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous reset, active-low.
- cfg_start  in  1  single-cycle pulse that starts a job.
- cfg_group_len  in  CNT_W  number of vectors per accumulation group.
- cfg_num_groups  in  CNT_W  number of groups in the job.
- s_valid  in  1  upstream vector valid.
- s_ready  out  1  upstream ready; equals FIFO not full.
- s_vector  in  DATA_W  upstream partial-sum vector.
- tx_valid  out  1  drives the accumulator in_valid.
- tx_vector  out  DATA_W  drives the accumulator in_vector.
- tx_accum_done  out  1  drives the accumulator in_accum_done; high on the last beat of a group.
- busy  out  1  high while a job is active.
- done  out  1  one-cycle pulse at job completion.

Behaviour:
- Reset: tx_valid=0, tx_vector=0, tx_accum_done=0, busy=0, done=0. FIFO empty, so s_ready=1 after reset. All counters 0, state IDLE.
- Input handshake: a push occurs on a cycle with s_valid & s_ready. Pushes are accepted in every state (prefetch allowed). There is no bypass: when the FIFO is full, s_ready=0 even if a pop happens the same cycle.
- All tx_* outputs are registered. A vector pushed at edge N into an empty FIFO while in STREAM appears on tx_* during cycle N+2 (earliest).
- State IDLE:
  - On cfg_start with both cfg values nonzero: latch len/groups, clear beat_cnt and grp_cnt, set busy=1, go STREAM.
  - On cfg_start with either value zero: no transfers, done pulses next cycle, stay IDLE.
- State STREAM, each cycle:
  - If the FIFO is non-empty: pop the head, register tx_valid=1, tx_vector=head, beat_cnt++.
  - Otherwise register tx_valid=0 (bubble). Bubbles are legal; the accumulator holds its state.
  - When the popped beat is beat_cnt==len-1: set tx_accum_done=1 on that same beat, clear beat_cnt, increment grp_cnt, go FLUSH.
- State FLUSH:
  - tx_valid=0 and tx_accum_done=0 for exactly FLUSH_CYC cycles; no pops.
  - Afterwards: if grp_cnt==groups, go DONE; else go STREAM.
- State DONE: done=1 for one cycle, busy=0, go IDLE.
- tx_accum_done is never high without tx_valid.
- tx_vector holds its last value when tx_valid=0.
- cfg_start while busy is ignored; latched config is unaffected.
- len==1: every beat carries tx_accum_done, each followed by a FLUSH.
- Counters are CNT_W wide with no wrap: maximum len and groups are 2^CNT_W-1.
- Reset mid-job: the job is aborted immediately, the FIFO is flushed (contents lost), and all outputs return to reset values.
- Data is never modified; lane order is preserved (lane i = bits [16i+15:16i]).

Decomposition:
- Shared package acc_pkg:
  - LANES=16, LANE_W=16, DATA_W=LANES*LANE_W.
  - State enum {IDLE, STREAM, FLUSH, DONE}.
  - Default FLUSH_CYC, shared with the acc_temporal latency budget.
- Sub-module acc_vec_fifo:
  - Synchronous FIFO: DATA_W x FIFO_DEPTH, with pointer wrap and full/empty flags.
  - Instantiated once.
- The FSM, counters and tx output registers live in acc_stream_tx.

Test Plan:
- len=4, groups=1, 4 vectors pushed back-to-back (lane0 = 1..4) -> tx_valid high 4 consecutive cycles; tx_accum_done only on the 4th beat; done pulses FLUSH_CYC+1 cycles after the last beat; busy low afterwards.
- len=3, groups=2, 6 vectors preloaded -> beats 3 and 6 carry accum_done; exactly FLUSH_CYC zero-valid cycles between beat 3 and beat 4; order preserved.
- Backpressure: no cfg_start, push 5 vectors, FIFO_DEPTH=4 -> s_ready=0 after the 4th push, 5th held. Then start len=5 -> all 5 transmitted in order; s_ready returns to 1.
- Starved input: len=2, one vector, 3-cycle gap, second vector -> tx_valid bubbles for 3 cycles; accum_done only on the second vector.
- cfg_group_len=0 start -> no tx_valid ever; done pulses the next cycle. cfg_start while busy -> ignored, original job completes unchanged.
- Assert rst_n low mid-group (after beat 2 of 4) -> all outputs 0 asynchronously, s_ready=1, FIFO empty. A new job after reset transmits only newly pushed data.
